ysyx_22051468_ifu_prefetch: RTL and testbench
=============================================

// Module: ysyx_22051468_ifu_prefetch
// PURPOSE
//  Parametrised fetch unit replacing the fixed PC register + single fetch flop: owns the PC, issues
//  pipelined in-order requests to instruction memory and buffers returned instructions in a
//  DEPTH-entry prefetch queue feeding decode over a valid/ready handshake. Supports redirect
//  (branch/jump/exception) with queue flush and discard of stale in-flight responses.
// PARAMETERS
//  WIDTH       64            address/PC width
//  INST_WIDTH  32            instruction width
//  DEPTH       4             queue entries = max in-flight+buffered; power of 2, >=2
//  RESET_PC    64'h80000000  first fetch address after reset
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           async active-low reset
//  req_valid_o    out  1           fetch request valid
//  req_addr_o     out  WIDTH       fetch address, [1:0]=0
//  req_ready_i    in   1           memory accepts request this cycle
//  rsp_valid_i    in   1           response valid (in order, <=1/cycle, >=1 cycle after accept)
//  rsp_inst_i     in   INST_WIDTH  response instruction
//  redirect_i     in   1           flush + restart fetch
//  redirect_pc_i  in   WIDTH       new PC; bits [1:0] ignored (forced 0)
//  inst_valid_o   out  1           queue head valid
//  inst_o         out  INST_WIDTH  queue head instruction
//  inst_addr_o    out  WIDTH       queue head PC
//  inst_ready_i   in   1           decode consumes head
//  occupancy_o    out  clog2(DEPTH)+1  entries currently in queue
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, queue empty, outstanding=0, discard=0, run=0; outputs:
//   req_valid_o=0, inst_valid_o=0, occupancy_o=0, inst_o/inst_addr_o=0, req_addr_o=RESET_PC.
//  run sets on first clk edge after rst_n rises; req_valid_o = run & ~redirect_i & (occ+outstanding<DEPTH).
//  req_addr_o = pc. Accept = req_valid_o & req_ready_i -> pc<=pc+4, outstanding+1.
//  Response: outstanding-1. If discard>0: discard-1, data dropped; else push {rsp_inst_i, addr}
//   into queue; addr comes from an internal DEPTH-entry address FIFO pushed on accept.
//  Credit rule guarantees a push never finds the queue full; a push while full is a bug (assert).
//  Pop = inst_valid_o & inst_ready_i; head advances next cycle. Push+pop same cycle: occ unchanged.
//  Empty queue: inst_valid_o=0; no bypass, response->inst_valid_o latency is 1 cycle.
//  Redirect (highest priority): next cycle queue empty, pc=redirect_pc_i&~3, address FIFO cleared,
//   discard<=outstanding_next (all in flight incl. one accepted/returned this cycle; a response in
//   the redirect cycle is dropped and not counted). Pop in redirect cycle ignored. req_valid_o=0
//   in the redirect cycle; fetch of new PC may be accepted the next cycle.
//  Discarded in-flight requests keep consuming credit until their response returns.
//  Counters are clog2(DEPTH)+1 bits; pointers clog2(DEPTH) bits, wrap modulo DEPTH.
//  Back-to-back redirects: second wins; discard recomputed from current outstanding.
// TESTING
//  Reset release -> cycle 1 req_valid_o=1, req_addr_o=0x80000000; queue empty, occ=0.
//  Ready mem, 1-cycle rsp, inst_ready=1 -> inst_addr_o 0x80000000,0x04,0x08,.. one per cycle, in order.
//  inst_ready=0, DEPTH=4 -> exactly 4 requests accepted, occ reaches 4, req_valid_o=0; no loss on release.
//  2 in flight, redirect to 0x80000100 -> both responses dropped, first inst_addr_o=0x80000100.
//  Redirect same cycle as rsp_valid_i and as accept -> both dropped, discard counts correctly.
//  rst_n pulled low mid-stream with occ=3 -> immediately inst_valid_o=0, occ=0; refetch from 0x80000000.

Source files
------------

// File: rtl/ysyx_22051468_ifu_prefetch.sv
// rtl/ysyx_22051468_ifu_prefetch.sv - fetch unit: PC owner, pipelined imem requests, prefetch queue
module ysyx_22051468_ifu_prefetch #(
  parameter int               WIDTH      = 64,
  parameter int               INST_WIDTH = 32,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(64'h8000_0000)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        req_valid_o,
  output logic [WIDTH-1:0]            req_addr_o,
  input  logic                        req_ready_i,
  input  logic                        rsp_valid_i,
  input  logic [INST_WIDTH-1:0]       rsp_inst_i,
  input  logic                        redirect_i,
  input  logic [WIDTH-1:0]            redirect_pc_i,
  output logic                        inst_valid_o,
  output logic [INST_WIDTH-1:0]       inst_o,
  output logic [WIDTH-1:0]            inst_addr_o,
  input  logic                        inst_ready_i,
  output logic [$clog2(DEPTH):0]      occupancy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0]      r_pc;
  logic                  r_run;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_discard;
  logic [CW-1:0]         r_occ;

  logic [INST_WIDTH-1:0] r_q_inst [DEPTH];
  logic [WIDTH-1:0]      r_q_addr [DEPTH];
  logic [AW-1:0]         r_q_wptr;
  logic [AW-1:0]         r_q_rptr;

  logic [WIDTH-1:0]      r_af_addr [DEPTH];
  logic [AW-1:0]         r_af_wptr;
  logic [AW-1:0]         r_af_rptr;

  logic [CW:0]           w_credit;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic [CW-1:0]         w_out_next;

  // Discarded requests still hold credit, so occupancy+outstanding never exceeds DEPTH.
  always_comb begin
    w_credit    = {1'b0, r_occ} + {1'b0, r_outstanding};
    req_valid_o = r_run & ~redirect_i & (w_credit < (CW+1)'(DEPTH));
    req_addr_o  = r_pc;
    w_accept    = req_valid_o & req_ready_i;
    w_push      = rsp_valid_i & ~redirect_i & (r_discard == '0);
    w_drop      = rsp_valid_i & ~redirect_i & (r_discard != '0);
    w_pop       = inst_valid_o & inst_ready_i & ~redirect_i;
    w_out_next  = r_outstanding + CW'(w_accept) - CW'(rsp_valid_i);
  end

  assign inst_valid_o = (r_occ != '0);
  assign inst_o       = r_q_inst[r_q_rptr];
  assign inst_addr_o  = r_q_addr[r_q_rptr];
  assign occupancy_o  = r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_run         <= 1'b0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_occ         <= '0;
      r_q_wptr      <= '0;
      r_q_rptr      <= '0;
      r_af_wptr     <= '0;
      r_af_rptr     <= '0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= w_out_next;
      if (redirect_i) begin
        r_pc      <= {redirect_pc_i[WIDTH-1:2], 2'b00};
        r_discard <= w_out_next;
        r_occ     <= '0;
        r_q_wptr  <= '0;
        r_q_rptr  <= '0;
        r_af_wptr <= '0;
        r_af_rptr <= '0;
      end else begin
        if (w_accept) begin
          r_pc      <= r_pc + WIDTH'(4);
          r_af_wptr <= r_af_wptr + AW'(1);
        end
        if (w_push) begin
          r_q_wptr  <= r_q_wptr + AW'(1);
          r_af_rptr <= r_af_rptr + AW'(1);
        end
        if (w_drop) r_discard <= r_discard - CW'(1);
        if (w_pop) r_q_rptr <= r_q_rptr + AW'(1);
        r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_inst[i]  <= '0;
        r_q_addr[i]  <= '0;
        r_af_addr[i] <= '0;
      end
    end else begin
      if (w_accept) r_af_addr[r_af_wptr] <= r_pc;
      if (w_push) begin
        r_q_inst[r_q_wptr] <= rsp_inst_i;
        r_q_addr[r_q_wptr] <= r_af_addr[r_af_rptr];
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_occ == CW'(DEPTH))));

endmodule

// File: tb/tb_ysyx_22051468_ifu_prefetch.sv
// tb/tb_ysyx_22051468_ifu_prefetch.sv - directed vector bench for the prefetch fetch unit
module tb_ysyx_22051468_ifu_prefetch;

  localparam logic [63:0] B = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_o;
  logic [63:0] req_addr_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_inst_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_o;
  logic        inst_ready_i;
  logic [2:0]  occupancy_o;

  ysyx_22051468_ifu_prefetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_inst_i(rsp_inst_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] ri;
    logic        redir;
    logic [31:0] rpc_off;
    logic        ird;
    logic        e_rv;
    logic [31:0] e_ra_off;
    logic        e_iv;
    logic [31:0] e_ia_off;
    logic [31:0] e_i;
    logic [2:0]  e_occ;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  function automatic vec_t v(logic rdy, logic rv, logic [31:0] ri, logic redir,
                             logic [31:0] rpc_off, logic ird, logic e_rv, logic [31:0] e_ra_off,
                             logic e_iv, logic [31:0] e_ia_off, logic [31:0] e_i, logic [2:0] e_occ);
    vec_t t;
    t.rdy = rdy; t.rv = rv; t.ri = ri; t.redir = redir; t.rpc_off = rpc_off; t.ird = ird;
    t.e_rv = e_rv; t.e_ra_off = e_ra_off; t.e_iv = e_iv; t.e_ia_off = e_ia_off;
    t.e_i = e_i; t.e_occ = e_occ;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] ri,
                       input logic redir, input logic [63:0] rpc, input logic ird);
    req_ready_i = rdy; rsp_valid_i = rv; rsp_inst_i = ri;
    redirect_i = redir; redirect_pc_i = rpc; inst_ready_i = ird;
  endtask

  vec_t vecs[30];
  logic        prev_acc;
  logic [63:0] prev_addr;
  logic [63:0] exp_addr;

  initial begin
    // Live instructions 1111_00xx; responses expected to be dropped are DEAD_000x.
    vecs[0]  = v(1,0,32'h0,0,0,1,            1,'h00, 0,0,0,0);
    vecs[1]  = v(1,1,32'h1111_0000,0,0,1,    1,'h04, 0,0,0,0);
    vecs[2]  = v(1,1,32'h1111_0001,0,0,1,    1,'h08, 1,'h00,32'h1111_0000,1);
    vecs[3]  = v(1,1,32'h1111_0002,0,0,1,    1,'h0C, 1,'h04,32'h1111_0001,1);
    vecs[4]  = v(1,1,32'h1111_0003,0,0,0,    1,'h10, 1,'h08,32'h1111_0002,1);
    vecs[5]  = v(1,1,32'h1111_0004,0,0,0,    1,'h14, 1,'h08,32'h1111_0002,2);
    vecs[6]  = v(1,1,32'h1111_0005,0,0,0,    0,'h18, 1,'h08,32'h1111_0002,3);
    vecs[7]  = v(1,0,32'h0,0,0,0,            0,'h18, 1,'h08,32'h1111_0002,4);
    vecs[8]  = v(1,0,32'h0,0,0,1,            0,'h18, 1,'h08,32'h1111_0002,4);
    vecs[9]  = v(1,0,32'h0,0,0,1,            1,'h18, 1,'h0C,32'h1111_0003,3);
    vecs[10] = v(0,1,32'h1111_0006,0,0,1,    1,'h1C, 1,'h10,32'h1111_0004,2);
    vecs[11] = v(1,0,32'h0,0,0,0,            1,'h1C, 1,'h14,32'h1111_0005,2);
    vecs[12] = v(1,0,32'h0,0,0,0,            1,'h20, 1,'h14,32'h1111_0005,2);
    vecs[13] = v(1,0,32'h0,1,'h103,1,        0,'h24, 1,'h14,32'h1111_0005,2);
    vecs[14] = v(0,1,32'hDEAD_0000,0,0,1,    1,'h100,0,0,0,0);
    vecs[15] = v(1,1,32'hDEAD_0001,0,0,1,    1,'h100,0,0,0,0);
    vecs[16] = v(0,1,32'h1111_0007,0,0,1,    1,'h104,0,0,0,0);
    vecs[17] = v(0,0,32'h0,0,0,1,            1,'h104,1,'h100,32'h1111_0007,1);
    vecs[18] = v(1,0,32'h0,0,0,1,            1,'h104,0,0,0,0);
    vecs[19] = v(1,1,32'h1111_000A,0,0,0,    1,'h108,0,0,0,0);
    vecs[20] = v(1,0,32'h0,0,0,0,            1,'h10C,1,'h104,32'h1111_000A,1);
    vecs[21] = v(1,1,32'hDEAD_0002,1,'h200,1,0,'h110,1,'h104,32'h1111_000A,1);
    vecs[22] = v(1,1,32'hDEAD_0003,0,0,1,    1,'h200,0,0,0,0);
    vecs[23] = v(0,1,32'h1111_0008,0,0,1,    1,'h204,0,0,0,0);
    vecs[24] = v(0,0,32'h0,0,0,1,            1,'h204,1,'h200,32'h1111_0008,1);
    vecs[25] = v(1,0,32'h0,1,'h300,1,        0,'h204,0,0,0,0);
    vecs[26] = v(1,0,32'h0,1,'h400,1,        0,'h300,0,0,0,0);
    vecs[27] = v(1,0,32'h0,0,0,1,            1,'h400,0,0,0,0);
    vecs[28] = v(0,1,32'h1111_0009,0,0,1,    1,'h404,0,0,0,0);
    vecs[29] = v(0,0,32'h0,0,0,0,            1,'h404,1,'h400,32'h1111_0009,1);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {63'b0, req_valid_o}, 64'd0);
    chk("rst_req_addr", req_addr_o, B);
    chk("rst_inst_valid", {63'b0, inst_valid_o}, 64'd0);
    chk("rst_occ", {61'b0, occupancy_o}, 64'd0);
    chk("rst_inst", {32'b0, inst_o}, 64'd0);
    chk("rst_inst_addr", inst_addr_o, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].ri, vecs[i].redir,
            B + {32'b0, vecs[i].rpc_off}, vecs[i].ird);
      #1;
      chk($sformatf("v%0d_req_valid", i), {63'b0, req_valid_o}, {63'b0, vecs[i].e_rv});
      chk($sformatf("v%0d_req_addr", i), req_addr_o, B + {32'b0, vecs[i].e_ra_off});
      chk($sformatf("v%0d_inst_valid", i), {63'b0, inst_valid_o}, {63'b0, vecs[i].e_iv});
      chk($sformatf("v%0d_occ", i), {61'b0, occupancy_o}, {61'b0, vecs[i].e_occ});
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d_inst_addr", i), inst_addr_o, B + {32'b0, vecs[i].e_ia_off});
        chk($sformatf("v%0d_inst", i), {32'b0, inst_o}, {32'b0, vecs[i].e_i});
      end
    end

    // Build occupancy 3, then pull reset asynchronously mid-cycle.
    @(negedge clk); drive(1, 0, 32'h0, 0, 0, 0);
    @(negedge clk); drive(1, 1, 32'h2222_0001, 0, 0, 0);
    @(negedge clk); drive(0, 1, 32'h2222_0002, 0, 0, 0);
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 0);
    #1;
    chk("mid_occ3", {61'b0, occupancy_o}, 64'd3);
    chk("mid_head_addr", inst_addr_o, B + 64'h400);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_inst_valid", {63'b0, inst_valid_o}, 64'd0);
    chk("async_rst_occ", {61'b0, occupancy_o}, 64'd0);
    chk("async_rst_req_valid", {63'b0, req_valid_o}, 64'd0);
    chk("async_rst_req_addr", req_addr_o, B);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming refetch: ready memory, one-cycle responses, decode always ready.
    prev_acc = 1'b0;
    prev_addr = '0;
    exp_addr = B;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1, prev_acc, 32'hC000_0000 | prev_addr[31:0] & 32'h0FFF_FFFF, 0, 0, 1);
      #1;
      prev_acc = req_valid_o & req_ready_i;
      prev_addr = req_addr_o;
      if (c == 0) begin
        chk("stream_first_req_valid", {63'b0, req_valid_o}, 64'd1);
        chk("stream_first_req_addr", req_addr_o, B);
      end
      if (c < 2) begin
        chk($sformatf("stream_c%0d_no_inst", c), {63'b0, inst_valid_o}, 64'd0);
      end else begin
        chk($sformatf("stream_c%0d_inst_valid", c), {63'b0, inst_valid_o}, 64'd1);
        chk($sformatf("stream_c%0d_inst_addr", c), inst_addr_o, exp_addr);
        chk($sformatf("stream_c%0d_inst", c), {32'b0, inst_o},
            {32'b0, 32'hC000_0000 | (exp_addr[31:0] & 32'h0FFF_FFFF)});
        exp_addr = exp_addr + 64'd4;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
